lsu_ctrl: RTL

- Load/store controller that sits directly upstream of the word-addressed data memory (128 x 32-bit words, 7-bit word address, registered read).
- Accepts byte-addressed load/store requests from the datapath through a valid/ready handshake.
- Issues the memory's mem_rd/mem_wr strobes and returns sign- or zero-extended load data with a single-cycle response pulse.
- Implements byte and halfword stores as read-modify-write, because the memory writes whole words only.

---
 rtl/lsu_pkg.sv | 8 +
 rtl/lsu_lane_align.sv | 27 ++
 rtl/lsu_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size and FSM-state encodings shared by the load/store controller.
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] mask;
    always_comb begin
        sh = size == SZ_HALF ? {off[1], 4'b0} : {off, 3'b0};
        h = 16'(word >> sh);
        b = h[7:0];
        rdata = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
                size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
        mask = size == SZ_BYTE ? 32'h0000_00ff << sh :
               size == SZ_HALF ? 32'h0000_ffff << sh : 32'hffff_ffff;
        merged = (word & ~mask) | ((wdata << sh) & mask);
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte-addressed load/store front end for a word-wide data memory;
// sub-word stores are done as read-modify-write.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state, next_state;
    logic r_we, r_uns, accept, bad, nx_err, unused_addr;
    logic [1:0] r_size, r_off;
    logic [DATA_W-1:0] r_wdata, ext, merged, nx_rdata, nx_wdata;

    assign accept = req_valid && req_ready;
    assign bad = req_size == SZ_ILL || (req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    lsu_lane_align u_align (
        .word(mem_rdata), .wdata(r_wdata), .off(r_off), .size(r_size), .uns(r_uns),
        .rdata(ext), .merged(merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_BYTE;
            r_off   <= 2'b00;
            r_wdata <= '0;
        end else if (accept) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_off   <= req_addr[1:0];
            r_wdata <= req_wdata;
        end
    end

    // Outputs are registered from next_state so each strobe lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= next_state;
            req_ready  <= next_state == IDLE;
            mem_rd     <= next_state == RD;
            mem_wr     <= next_state == WR;
            resp_valid <= next_state == DONE;
            resp_rdata <= nx_rdata;
            resp_err   <= nx_err;
            mem_wdata  <= nx_wdata;
            if (accept) mem_addr <= req_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = !accept ? IDLE : bad ? DONE :
                                  (req_we && req_size == SZ_WORD) ? WR : RD;
            RD:      next_state = RWAIT;
            RWAIT:   next_state = r_we ? WR : DONE;
            WR:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        nx_rdata = next_state != DONE ? resp_rdata : (state == RWAIT && !r_we) ? ext : '0;
        nx_err   = next_state != DONE ? resp_err : state == IDLE;
        nx_wdata = accept ? req_wdata : (state == RWAIT && r_we) ? merged : mem_wdata;
    end
endmodule
